ref_rail_sequencer: RTL and testbench
=====================================

// Module: ref_rail_sequencer
// PURPOSE
//   Parametrised power-up/power-down sequencer for the analog reference rails on the ua[] pins.
//   Enables up to NCH reference channels one at a time, in ascending index order.
//   Each step waits for a settle delay and the channel's ready comparator before the next.
//   Shuts channels down in reverse order; any fault forces all channels off at once.
//   Sits between the tt_um top level (ui_in/uio_in config) and the analog switch enables.
// PARAMETERS
//   NCH       6     number of reference channels (ua[5:0] usable)
//   SETTLE_W  8     width of settle_cycles and of the settle down-counter
//   TIMEOUT   1023  ready-wait limit in cycles (used only with SEQ_READY_TIMEOUT_EN)
// PORTS
//   clk           in   1         clock
//   rst_n         in   1         async active-low reset
//   ena           in   1         design enable; ena=0 is treated as start=0
//   start         in   1         level request: 1=power up, 0=power down
//   settle_cycles in   SETTLE_W  per-step settle delay S
//   ch_mask       in   NCH       channels to sequence; latched on leaving OFF
//   ch_ready      in   NCH       async ready comparators; 2-flop synchronised inside
//   fault_in      in   1         async fault; 2-flop synchronised inside
//   fault_clr     in   1         clears FAULT when start=0
//   ch_en         out  NCH       registered channel enables
//   busy          out  1         1 in UP_EN/UP_WAIT/DOWN
//   up_done       out  1         1 in ON
//   fault         out  1         1 in FAULT
//   state         out  3         encoded FSM state
// BEHAVIOUR
//   Reset: ch_en=0, busy=0, up_done=0, fault=0, state=OFF, idx=0, counter=0, mask latch=0.
//   States and encodings: OFF=0, UP_EN=1, UP_WAIT=2, ON=3, DOWN=4, FAULT=5.
//   OFF
//     - start&ena: latch ch_mask.
//     - Latched mask==0: go directly to ON.
//     - Otherwise: idx=lowest set bit, go to UP_EN.
//   UP_EN (1 cycle): set ch_en[idx]=1, load counter=S, go to UP_WAIT.
//   UP_WAIT
//     - Counter decrements to 0 and holds there.
//     - Exit when counter==0 and ready_sync[idx]==1.
//     - Exit target: next higher set mask bit -> UP_EN; if none -> ON.
//     - With ready already high, consecutive ch_en rises are S+2 cycles apart (S=0 -> 2).
//   ON: up_done=1. On start=0 or ena=0: idx=highest set ch_en bit, load counter=S, go to DOWN.
//   DOWN
//     - When counter==0: clear ch_en[idx], reload S, move idx to next lower set bit.
//     - No ready wait.
//     - When ch_en==0: go to OFF.
//   Abort during power-up: start=0 (or ena=0) in UP_EN/UP_WAIT goes to DOWN.
//     The already-enabled channels are then cleared in reverse order.
//   Re-request during DOWN: start=1 is ignored until OFF is reached.
//   Faults
//     - fault_sync=1 in any state: next edge gives ch_en=0 and state FAULT.
//     - Fault has priority over every other event in the same cycle.
//     - FAULT exits to OFF only on fault_clr=1 & start=0 & fault_sync=0.
//     - fault_clr with start=1 is ignored.
//   ch_mask changes after the latch are ignored until the next OFF->up transition.
//   Counter arithmetic is unsigned SETTLE_W; it never wraps below 0.
// CONFIGURATION
//   SEQ_READY_TIMEOUT_EN defined
//     - UP_WAIT runs a wait counter cleared on entry.
//     - If it reaches TIMEOUT before the exit condition: go to FAULT with all ch_en cleared.
//   SEQ_READY_TIMEOUT_EN undefined
//     - UP_WAIT waits indefinitely for ready.
//     - No timeout counter logic is synthesised.
// TESTING
//   1. mask=6'b000111, S=3, ready all 1, start=1
//        -> ch_en bits 0,1,2 rise 5 cycles apart; then up_done=1, busy=0.
//   2. From ON with mask=000111, start=0
//        -> ch_en bits 2,1,0 fall 4 cycles apart; then state=OFF.
//   3. mask=000011, ready[1] held 0 for 20 cycles
//        -> ch_en[1] stays 1 and ch_en[0] stays 1; step completes 3 cycles after ready[1] rises.
//   4. fault_in pulse mid-UP_WAIT
//        -> ch_en=0 within 3 cycles, fault=1.
//        -> fault_clr with start=1 ignored; fault_clr with start=0 -> OFF.
//   5. start drops after ch_en[0] is set (mask=000101)
//        -> ch_en[2] never set; ch_en[0] cleared after S+1 cycles; state=OFF.
//   6. SEQ_READY_TIMEOUT_EN, TIMEOUT=16, ready[0]=0
//        -> FAULT 16 cycles after UP_WAIT entry; with macro off, stays in UP_WAIT.
//   Also: rst_n asserted mid-sequence -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ref_rail_sequencer.sv
// ref_rail_sequencer: powers reference rails up in ascending order and down in reverse; faults force all off.
// Optional ready-wait timeout is enabled by defining SEQ_READY_TIMEOUT_EN.
module ref_rail_sequencer #(
  parameter int NCH = 6,
  parameter int SETTLE_W = 8
`ifdef SEQ_READY_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [NCH-1:0]      ch_ready,
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic [NCH-1:0]      ch_en,
  output logic                busy,
  output logic                up_done,
  output logic                fault,
  output logic [2:0]          state
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [2:0] {OFF = 3'd0, UP_EN = 3'd1, UP_WAIT = 3'd2, ON = 3'd3, DOWN = 3'd4, FAULT = 3'd5} state_t;
  function automatic logic [IW:0] lo_above(input logic [NCH-1:0] v, input int lim);
    logic [IW:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) if (v[k] && k > lim) r = {1'b1, IW'(k)};
    return r;
  endfunction
  function automatic logic [IW-1:0] hi_below(input logic [NCH-1:0] v, input int lim);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) if (v[k] && k < lim) r = IW'(k);
    return r;
  endfunction
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]      mask_q, mask_d, en_q, en_d;
  logic [NCH-1:0]      rdy_s1_q, rdy_s2_q;
  logic                flt_s1_q, flt_s2_q;
  logic                busy_q, up_done_q, fault_q;
  logic                go;
  logic [IW:0]         lo, nxt;
`ifdef SEQ_READY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]       wcnt_q, wcnt_d;
`endif
  always_comb begin
    go = start & ena;
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    en_d = en_q;
`ifdef SEQ_READY_TIMEOUT_EN
    wcnt_d = '0;
`endif
    lo = lo_above(ch_mask, -1);
    nxt = lo_above(mask_q, int'(idx_q));
    if (flt_s2_q) begin
      state_d = FAULT;
      en_d = '0;
    end else if (!go && (state_q == UP_EN || state_q == UP_WAIT || state_q == ON)) begin
      state_d = DOWN;
      idx_d = hi_below(en_q, NCH);
      cnt_d = settle_cycles;
    end else begin
      case (state_q)
        OFF: if (go) begin
          mask_d = ch_mask;
          idx_d = lo[IW-1:0];
          state_d = lo[IW] ? UP_EN : ON;
        end
        UP_EN: begin
          en_d[idx_q] = 1'b1;
          cnt_d = settle_cycles;
          state_d = UP_WAIT;
        end
        UP_WAIT: begin
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
          if (cnt_q == '0 && rdy_s2_q[idx_q]) begin
            state_d = nxt[IW] ? UP_EN : ON;
            idx_d = nxt[IW] ? nxt[IW-1:0] : idx_q;
          end
`ifdef SEQ_READY_TIMEOUT_EN
          else if (wcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = FAULT;
            en_d = '0;
          end else wcnt_d = wcnt_q + 1'b1;
`endif
        end
        DOWN: if (en_q == '0) begin
          state_d = OFF;
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          en_d[idx_q] = 1'b0;
          cnt_d = settle_cycles;
          idx_d = hi_below(en_q, int'(idx_q));
        end else cnt_d = cnt_q - 1'b1;
        FAULT: if (fault_clr && !go) begin
          state_d = OFF;
          idx_d = '0;
          cnt_d = '0;
        end
        ON: ;
        default: state_d = OFF;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      idx_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      en_q <= '0;
      rdy_s1_q <= '0;
      rdy_s2_q <= '0;
      flt_s1_q <= 1'b0;
      flt_s2_q <= 1'b0;
      busy_q <= 1'b0;
      up_done_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef SEQ_READY_TIMEOUT_EN
      wcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      en_q <= en_d;
      rdy_s1_q <= ch_ready;
      rdy_s2_q <= rdy_s1_q;
      flt_s1_q <= fault_in;
      flt_s2_q <= flt_s1_q;
      busy_q <= (state_d == UP_EN) || (state_d == UP_WAIT) || (state_d == DOWN);
      up_done_q <= state_d == ON;
      fault_q <= state_d == FAULT;
`ifdef SEQ_READY_TIMEOUT_EN
      wcnt_q <= wcnt_d;
`endif
    end
  end
  assign ch_en = en_q;
  assign busy = busy_q;
  assign up_done = up_done_q;
  assign fault = fault_q;
  assign state = state_q;
endmodule

// File: tb/tb_ref_rail_sequencer.sv
// tb_ref_rail_sequencer: directed power-up/down, abort, fault, timeout and reset checks.
module tb_ref_rail_sequencer;
  logic       clk, rst_n, ena, start, fault_in, fault_clr;
  logic [7:0] settle_cycles;
  logic [5:0] ch_mask, ch_ready, ch_en;
  logic       busy, up_done, fault;
  logic [2:0] state;
  int         n_cmp = 0;
  int         n_err = 0;
  ref_rail_sequencer #(
    .NCH(6),
    .SETTLE_W(8)
`ifdef SEQ_READY_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .settle_cycles(settle_cycles),
    .ch_mask(ch_mask), .ch_ready(ch_ready), .fault_in(fault_in), .fault_clr(fault_clr),
    .ch_en(ch_en), .busy(busy), .up_done(up_done), .fault(fault), .state(state)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
    settle_cycles = 8'd3; ch_mask = '0; ch_ready = 6'h3F;
    tick(3);
    chk("rst_state", state, 0); chk("rst_ch_en", ch_en, 0); chk("rst_busy", busy, 0);
    chk("rst_up_done", up_done, 0); chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    tick(2);
    // power up 0,1,2 with S=3; mask change after latch must not matter
    ch_mask = 6'b000111; start = 1'b1;
    tick(1); chk("t1_up_en", state, 1); chk("t1_busy", busy, 1); chk("t1_en0_pre", ch_en, 0);
    ch_mask = 6'h3F;
    tick(1); chk("t1_en0", ch_en, 6'b000001); chk("t1_wait", state, 2);
    tick(4); chk("t1_en0_hold", ch_en, 6'b000001);
    tick(1); chk("t1_en1", ch_en, 6'b000011);
    tick(5); chk("t1_en2", ch_en, 6'b000111);
    tick(3); chk("t1_wait_last", state, 2);
    tick(1); chk("t1_on", state, 3); chk("t1_up_done", up_done, 1); chk("t1_busy_off", busy, 0);
    // power down 2,1,0; a re-request during DOWN is ignored
    start = 1'b0;
    tick(1); chk("t2_down", state, 4); chk("t2_busy", busy, 1);
    tick(3); chk("t2_en_hold", ch_en, 6'b000111);
    tick(1); chk("t2_clr2", ch_en, 6'b000011);
    tick(4); chk("t2_clr1", ch_en, 6'b000001);
    start = 1'b1;
    tick(4); chk("t2_clr0", ch_en, 0); chk("t2_still_down", state, 4);
    tick(1); chk("t2_off", state, 0);
    start = 1'b0;
    tick(1); chk("t2_off_stay", state, 0);
    // ready[1] held low
    ch_mask = 6'b000011; ch_ready = 6'b111101;
    tick(2); start = 1'b1;
    tick(7); chk("t3_en01", ch_en, 6'b000011);
    tick(20); chk("t3_wait", state, 2); chk("t3_en_hold", ch_en, 6'b000011);
    ch_ready = 6'h3F;
    tick(2); chk("t3_wait_sync", state, 2);
    tick(1); chk("t3_on", state, 3);
    start = 1'b0;
    tick(10); chk("t3_off", state, 0); chk("t3_en_off", ch_en, 0);
    // fault pulse mid-UP_WAIT
    ch_mask = 6'b000111; start = 1'b1;
    tick(2); chk("t4_en0", ch_en, 6'b000001);
    tick(1); fault_in = 1'b1;
    tick(1); fault_in = 1'b0;
    tick(1); chk("t4_pre_fault", ch_en, 6'b000001);
    tick(1); chk("t4_fault_st", state, 5); chk("t4_fault", fault, 1); chk("t4_en_off", ch_en, 0);
    chk("t4_busy", busy, 0);
    fault_clr = 1'b1;
    tick(3); chk("t4_clr_ignored", state, 5);
    start = 1'b0;
    tick(1); chk("t4_clr", state, 0); chk("t4_fault_clr", fault, 0);
    fault_clr = 1'b0;
    // abort after ch_en[0] with mask 000101
    ch_mask = 6'b000101; start = 1'b1;
    tick(2); chk("t5_en0", ch_en, 6'b000001);
    start = 1'b0;
    tick(1); chk("t5_down", state, 4);
    tick(3); chk("t5_hold", ch_en, 6'b000001);
    tick(1); chk("t5_clr", ch_en, 0);
    tick(1); chk("t5_off", state, 0);
    // S=0: rises 2 cycles apart
    settle_cycles = 8'd0; ch_mask = 6'b000011; start = 1'b1;
    tick(2); chk("s0_en0", ch_en, 6'b000001);
    tick(2); chk("s0_en1", ch_en, 6'b000011);
    tick(1); chk("s0_on", state, 3);
    start = 1'b0;
    tick(2); chk("s0_clr1", ch_en, 6'b000001);
    tick(2); chk("s0_off", state, 0);
    settle_cycles = 8'd3;
    // empty mask goes straight to ON; ena=0 acts as start=0
    ch_mask = '0; start = 1'b1;
    tick(1); chk("m0_on", state, 3); chk("m0_up_done", up_done, 1); chk("m0_en", ch_en, 0);
    ena = 1'b0;
    tick(1); chk("ena0_down", state, 4);
    tick(1); chk("ena0_off", state, 0);
    ena = 1'b1; start = 1'b0;
    tick(1);
    // ready[0] never rises
    ch_ready = 6'b111110; ch_mask = 6'b000001;
    tick(2); start = 1'b1;
    tick(2); chk("t6_wait", state, 2);
    tick(15); chk("t6_wait_15", state, 2);
    tick(1);
`ifdef SEQ_READY_TIMEOUT_EN
    chk("t6_timeout", state, 5); chk("t6_en_off", ch_en, 0);
`else
    chk("t6_no_timeout", state, 2); chk("t6_en_hold", ch_en, 6'b000001);
    tick(10); chk("t6_still_wait", state, 2);
`endif
    start = 1'b0; fault_clr = 1'b1; ch_ready = 6'h3F;
    tick(8); chk("t6_off", state, 0);
    fault_clr = 1'b0;
    // async reset mid-sequence
    ch_mask = 6'b000111; start = 1'b1;
    tick(8); chk("ar_pre", ch_en, 6'b000011);
    #2 rst_n = 1'b0;
    #1 chk("ar_state", state, 0); chk("ar_en", ch_en, 0); chk("ar_busy", busy, 0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    tick(2); chk("ar_after", state, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
